// File: rtl/lvds_lane_err_mon.sv
// rtl/lvds_lane_err_mon.sv - per-lane P/N word compare error monitor with lock FSM; optional ERR_BITCOUNT_EN
module lvds_lane_err_mon #(
    parameter int LANES    = 2,
    parameter int DW       = 7,
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 64,
    parameter int LOSS_CNT = 4
) (
    input  logic                   I_clk,
    input  logic                   I_rst,
    input  logic                   I_clr,
    input  logic                   I_data_vld,
    input  logic [LANES-1:0]       I_lane_dpa_done,
    input  logic [LANES*DW-1:0]    I_diff_pdata,
    input  logic [LANES*DW-1:0]    I_diff_ndata,
    output logic [LANES-1:0]       O_error_flag,
    output logic [LANES-1:0]       O_err_sticky,
    output logic [LANES*CNT_W-1:0] O_err_cnt,
    output logic [LANES-1:0]       O_lane_lock,
    output logic                   O_any_error
);

    localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int INC_W   = $clog2(DW + 1);
    localparam int SUM_W   = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEEK, ST_LOCKED} state_t;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DW-1:0]    p_w, n_w;
        logic             sample_w, mism_w;
        logic [INC_W-1:0] inc_w;
        logic [SUM_W-1:0] sum_w;
        logic [CNT_W-1:0] cnt_d, cnt_q;
        logic             flag_q, sticky_q, lock_q;
        logic [RUN_W-1:0] run_q;
        state_t           state_q;

        always_comb begin
            p_w      = I_diff_pdata[k*DW +: DW];
            n_w      = I_diff_ndata[k*DW +: DW];
            sample_w = I_data_vld & I_lane_dpa_done[k];
            mism_w   = sample_w && (p_w != n_w);
`ifdef ERR_BITCOUNT_EN
            inc_w    = INC_W'($countones(p_w ^ n_w));
`else
            inc_w    = INC_W'(1);
`endif
            // Sum is one bit wider than either operand so overflow is visible before clamping
            sum_w    = SUM_W'(cnt_q) + SUM_W'(inc_w);
            cnt_d    = (sum_w > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_w[CNT_W-1:0];
        end

        always_ff @(posedge I_clk or posedge I_rst) begin
            if (I_rst) begin
                flag_q   <= 1'b0;
                sticky_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                flag_q <= mism_w;
                if (I_clr) begin
                    sticky_q <= 1'b0;
                    cnt_q    <= '0;
                end else if (mism_w) begin
                    sticky_q <= 1'b1;
                    cnt_q    <= cnt_d;
                end
            end
        end

        // Losing DPA overrides every other transition
        always_ff @(posedge I_clk or posedge I_rst) begin
            if (I_rst) begin
                state_q <= ST_IDLE;
                run_q   <= '0;
                lock_q  <= 1'b0;
            end else if (!I_lane_dpa_done[k]) begin
                state_q <= ST_IDLE;
                run_q   <= '0;
                lock_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_SEEK;
                        run_q   <= '0;
                    end
                    ST_SEEK: if (I_data_vld) begin
                        if (mism_w) begin
                            run_q <= '0;
                        end else if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                            state_q <= ST_LOCKED;
                            run_q   <= '0;
                            lock_q  <= 1'b1;
                        end else begin
                            run_q <= run_q + RUN_W'(1);
                        end
                    end
                    ST_LOCKED: if (I_data_vld) begin
                        if (!mism_w) begin
                            run_q <= '0;
                        end else if (run_q == RUN_W'(LOSS_CNT - 1)) begin
                            state_q <= ST_SEEK;
                            run_q   <= '0;
                            lock_q  <= 1'b0;
                        end else begin
                            run_q <= run_q + RUN_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        run_q   <= '0;
                        lock_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign O_error_flag[k]              = flag_q;
        assign O_err_sticky[k]              = sticky_q;
        assign O_err_cnt[k*CNT_W +: CNT_W]  = cnt_q;
        assign O_lane_lock[k]               = lock_q;
    end

    assign O_any_error = |O_error_flag;

endmodule
